imem_loader: RTL and testbench
==============================

# imem_loader

Program loader that writes the instruction memory. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word is written to consecutive instruction-memory word addresses through a registered write port. While a load is in progress it holds the pipelined core in stall so the fetch side never reads a partially written program.

## Interface
Parameters:
- DEPTH, 64: instruction-memory depth in 32-bit words (256 bytes).
- ADDR_W, 6: word-address width, equal to log2(DEPTH).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  begins a load session; sampled only in IDLE.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction-memory write enable, one cycle per word.
- mem_addr  out  ADDR_W  word address (pc[ADDR_W+1:2] equivalent).
- mem_wdata  out  32  instruction word.
- core_hold  out  1  stalls the core; high in every state except IDLE.
- busy  out  1  equal to core_hold.
- done  out  1  one-cycle pulse at the end of a session.
- err  out  1  sticky flag for length overflow.

## Operation
- Byte transfer occurs when rx_valid && rx_ready.
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4·N data bytes. Each word is little-endian: first byte goes to bits [7:0].
- States:
  - IDLE: rx_ready=0. Moves to LEN_LO when start=1. Also clears err and the word index.
  - LEN_LO: rx_ready=1. On transfer, latches N[7:0] and moves to LEN_HI.
  - LEN_HI: rx_ready=1. On transfer, latches N[15:8]. Moves to DONE if N==0, otherwise to DATA. Sets err if N>DEPTH.
  - DATA: rx_ready=1. A 2-bit byte counter shifts bytes into the word register. On the 4th transfer, moves to WRITE.
  - WRITE: rx_ready=0. mem_we=1 only if index<DEPTH, with mem_addr=index[ADDR_W-1:0] and mem_wdata=the assembled word. Then index increments. Moves to DONE if index+1==N, otherwise to DATA.
  - DONE: rx_ready=0, done=1. Moves to IDLE.
- Word index is 16 bits wide and does not wrap within a session.
- Words with index≥DEPTH are consumed but never written (mem_we stays 0).
- start is ignored outside IDLE.
- rx_valid is ignored whenever rx_ready=0; the byte is not consumed.
- Memory contents are never cleared by this block.

## Timing
- Reset values: rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_hold=0, busy=0, done=0, err=0. State is IDLE.
- Reset mid-session aborts immediately. Words already written remain in memory; a partial word is discarded.
- All outputs are registered or decoded from state only. No combinational path exists from rx_valid to rx_ready.
- start high at cycle t: core_hold=1 and rx_ready=1 from t+1.
- Last byte of a word transferred at cycle k: mem_we=1 at k+1. Next byte can be accepted at k+2 at the earliest.
- Last byte of the session transferred at k: write at k+1, done=1 at k+2, core_hold=0 from k+3.
- N==0 with LEN_HI transferred at k: done=1 at k+1, core_hold=0 from k+2, no writes.
- Peak throughput is one word per 5 cycles.
- err asserts the cycle after the LEN_HI transfer and holds until reset or the next accepted start.

## Test plan
- Fibonacci load. Stimulus: start, then bytes 06 00 and the 24 bytes of 00060613, 00168693, 00C68733, 00068613, 00070693, FE06DAE3, with continuous valid. Required response: exactly six mem_we pulses at addr 0..5 with those words, one done pulse, core_hold low 3 cycles after the last byte, err=0.
- Zero length. Stimulus: start, bytes 00 00. Required response: no mem_we, done exactly 1 cycle after the LEN_HI transfer, core_hold low the cycle after done.
- Backpressure and gaps. Stimulus: load 2 words (DEADBEEF, 12345678) with rx_valid randomly deasserted, and a byte held valid during the WRITE cycle. Required response: the held byte is accepted on the following cycle, writes are addr0=DEADBEEF and addr1=12345678, and no byte is lost or duplicated.
- Overflow. Stimulus: N=65 (41 00), word i = i. Required response: err=1 from the cycle after LEN_HI, writes at addr 0..63 only, the 65th word is consumed without mem_we, done pulses, err stays 1 in IDLE.
- Reset mid-load. Stimulus: assert rst_n=0 after 2 bytes of word 1 in a 3-word load. Required response: all outputs are 0 while reset is low. A fresh 1-word load of 00000013 then writes addr0 with 00000013.
- Start while busy. Stimulus: pulse start during DATA. Required response: no restart, index and err unchanged, and the session completes normally.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory program loader: assembles a length-prefixed little-endian
// byte stream into 32-bit words, writes them to consecutive word addresses and stalls the core meanwhile.
module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [16:0] DEPTH_X = 17'(DEPTH);

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [15:0]         idx_q, idx_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [31:0]         word_q, word_d;
    logic                err_q, err_d;

    logic                rx_ready_q, rx_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                hold_q, hold_d;
    logic                done_q, done_d;

    logic                xfer_s;
    logic [15:0]         len_full_s;
    logic                idx_in_range_s;
    logic                last_word_s;

    // rx_ready is a registered state decode, so a transfer never depends combinationally on itself
    assign xfer_s         = rx_valid && rx_ready_q;
    assign len_full_s     = {rx_data, len_q[7:0]};
    assign idx_in_range_s = ({1'b0, idx_q} < DEPTH_X);
    assign last_word_s    = (({1'b0, idx_q} + 17'd1) == {1'b0, len_q});

    // Next-state and datapath update for the load session
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                idx_d = 16'd0;
                cnt_d = 2'd0;
                if (start) begin
                    err_d   = 1'b0;
                    state_d = S_LEN_LO;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LEN_LO: begin
                if (xfer_s) begin
                    len_d   = {len_q[15:8], rx_data};
                    state_d = S_LEN_HI;
                end else begin
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_HI: begin
                if (xfer_s) begin
                    len_d   = len_full_s;
                    err_d   = err_q | ({1'b0, len_full_s} > DEPTH_X);
                    state_d = (len_full_s == 16'd0) ? S_DONE : S_DATA;
                end else begin
                    state_d = S_LEN_HI;
                end
            end
            S_DATA: begin
                if (xfer_s) begin
                    // first byte of a word ends up in bits [7:0] after four shifts
                    word_d  = {rx_data, word_q[31:8]};
                    cnt_d   = cnt_q + 2'd1;
                    state_d = (cnt_q == 2'd3) ? S_WRITE : S_DATA;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_WRITE: begin
                idx_d   = idx_q + 16'd1;
                state_d = last_word_s ? S_DONE : S_DATA;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output register inputs, derived from the state being entered
    always_comb begin
        rx_ready_d  = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hold_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        case (state_d)
            S_LEN_LO, S_LEN_HI, S_DATA: begin
                rx_ready_d = 1'b1;
            end
            default: begin
                rx_ready_d = 1'b0;
            end
        endcase
        if (state_d == S_WRITE) begin
            // out-of-range words are consumed silently
            mem_we_d    = idx_in_range_s;
            mem_addr_d  = idx_q[ADDR_W-1:0];
            mem_wdata_d = word_d;
        end else begin
            mem_we_d = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= 16'd0;
            idx_q   <= 16'd0;
            cnt_q   <= 2'd0;
            word_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            err_q   <= err_d;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            hold_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            rx_ready_q  <= rx_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hold_q      <= hold_d;
            done_q      <= done_d;
        end
    end

    assign rx_ready  = rx_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign core_hold = hold_q;
    assign busy      = hold_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a driver pushes expected writes/done pulses
// into queues as it streams bytes; a negedge monitor pops and compares.
module tb_imem_loader;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_hold;
    logic              busy;
    logic              done;
    logic              err;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_hold(core_hold), .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        int          cyc;
        logic [ADDR_W-1:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wr_q[$];
    int          done_q[$];
    logic [31:0] wq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_done = -10;
    logic        err_old = 1'b0;
    logic        err_new = 1'b0;
    int          err_eff = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    function automatic logic exp_err_at(input int c);
        return (c >= err_eff) ? err_new : err_old;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // monitor
    initial begin
        wr_t w;
        int  d;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("busy_eq_hold", {31'd0, busy}, {31'd0, core_hold});
                chk("err_flag", {31'd0, err}, {31'd0, exp_err_at(cyc)});
                if (mem_we) begin
                    if (wr_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_write: addr %0d data %h at cycle %0d, none expected", mem_addr, mem_wdata, cyc);
                    end else begin
                        w = wr_q.pop_front();
                        chk("write_cycle", cyc, w.cyc);
                        chk("write_addr", {26'd0, mem_addr}, {26'd0, w.addr});
                        chk("write_data", mem_wdata, w.data);
                    end
                end
                if (done) begin
                    if (done_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done: done at cycle %0d, none expected", cyc);
                    end else begin
                        d = done_q.pop_front();
                        chk("done_cycle", cyc, d);
                    end
                    last_done = cyc;
                end
                if (cyc == last_done + 1) begin
                    chk("hold_low_after_done", {31'd0, core_hold}, 32'd0);
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_mem_addr"}, {26'd0, mem_addr}, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_core_hold"}, {31'd0, core_hold}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct, input bit pulse_start, output int k);
        int waited;
        bit got;
        k = -1;
        while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            start    = pulse_start;
            pulse_start = 1'b0;
            tick();
            start = 1'b0;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        waited   = 0;
        got      = 1'b0;
        while (!got && waited < 16) begin
            got   = rx_ready;
            k     = cyc;
            start = pulse_start;
            pulse_start = 1'b0;
            tick();
            start = 1'b0;
            waited++;
        end
        rx_valid = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL byte_timeout: byte %h not accepted within 16 cycles", b);
        end
    endtask

    // One session over wq; busy_start_byte / abort_byte select a data-byte index (-1 = none)
    task automatic session(input int n, input int gap_pct, input int busy_start_byte, input int abort_byte);
        int  k, last_k, t, bi, g;
        wr_t w;
        t = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        err_old = exp_err_at(t);
        err_new = 1'b0;
        err_eff = t + 1;
        chk("hold_after_start", {31'd0, core_hold}, 32'd1);
        chk("ready_after_start", {31'd0, rx_ready}, 32'd1);
        send_byte(8'(n), gap_pct, 1'b0, k);
        if (gap_pct == 0) chk("len_lo_cycle", k, t + 1);
        last_k = k;
        send_byte(8'(n >> 8), gap_pct, 1'b0, k);
        if (gap_pct == 0) chk("len_hi_cycle", k, last_k + 1);
        last_k  = k;
        err_old = exp_err_at(k);
        err_new = (n > DEPTH);
        err_eff = k + 1;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) begin
                bi = i * 4 + j;
                if (bi == abort_byte) begin
                    rst_n = 1'b0;
                    rx_valid = 1'b0;
                    err_old = 1'b0; err_new = 1'b0; err_eff = 0;
                    #2;
                    chk_all_zero("abort");
                    tick(); tick();
                    chk_all_zero("abort_held");
                    rst_n = 1'b1;
                    tick();
                    chk("write_q_after_abort", wr_q.size(), 0);
                    wr_q.delete();
                    done_q.delete();
                    return;
                end
                g = (j == 0 && i > 0) ? 0 : gap_pct;
                send_byte(8'(wq[i] >> (8 * j)), g, (bi == busy_start_byte), k);
                if (j == 0 && i > 0) chk("held_byte_cycle", k, last_k + 2);
                else if (gap_pct == 0) chk("data_byte_cycle", k, last_k + 1);
                last_k = k;
            end
            if (i < DEPTH) begin
                w.cyc  = k + 1;
                w.addr = ADDR_W'(i);
                w.data = wq[i];
                wr_q.push_back(w);
            end
        end
        done_q.push_back((n == 0) ? last_k + 1 : last_k + 2);
        g = 0;
        while (done_q.size() != 0 && g < 12) begin
            tick();
            g++;
        end
        if (done_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL done_timeout: no done pulse within 12 cycles");
            done_q.delete();
        end
        tick(); tick();
        chk("writes_outstanding", wr_q.size(), 0);
        wr_q.delete();
    endtask

    initial begin
        int n;
        rst_n = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
        #1 rst_n = 1'b0;
        #11;
        chk_all_zero("reset");
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Fibonacci program
        wq = '{32'h00060613, 32'h00168693, 32'h00C68733, 32'h00068613, 32'h00070693, 32'hFE06DAE3};
        session(6, 0, -1, -1);

        // zero length
        wq.delete();
        session(0, 0, -1, -1);

        // backpressure with random gaps
        wq = '{32'hDEADBEEF, 32'h12345678};
        session(2, 40, -1, -1);

        // overflow: 65 words, word i = i
        wq.delete();
        for (int i = 0; i < 65; i++) wq.push_back(32'(i));
        session(65, 0, -1, -1);
        repeat (4) tick();

        // start pulse while busy
        wq = '{32'hCAFEF00D, 32'h0BADC0DE, 32'h55AA33CC};
        session(3, 0, 5, -1);

        // reset after two bytes of the second word, then a fresh single-word load
        wq = '{32'h11111111, 32'h22222222, 32'h33333333};
        session(3, 0, -1, 6);
        wq = '{32'h00000013};
        session(1, 0, -1, -1);

        // random sessions
        for (int s = 0; s < 8; s++) begin
            n = $urandom_range(5, 0);
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back($urandom);
            session(n, (s % 2 == 0) ? 0 : 35, -1, -1);
            repeat ($urandom_range(3, 0)) tick();
        end

        chk("final_write_q", wr_q.size(), 0);
        chk("final_done_q", done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
